// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types for the fetch/data memory port arbiter.
//   FSM state encoding, transaction owner encoding, funct3 size codes,
//   and the alignment check used to reject data accesses before they
//   reach the memory.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_ERR} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes never fault.
   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
      case (size)
         SZ_H, SZ_HU: return a[0];
         SZ_W:        return a != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick
//   Combinational requester selection. Data wins ties unless fetch has
//   already waited through MAX_DSTREAK consecutive data grants.
//   Ports:
//     if_req, d_req   pending requests
//     dstreak         consecutive data grants taken while fetch waited
//     pick_if, pick_d one-hot (or both 0) selection
module arb_pick #(
   parameter int MAX_DSTREAK = 4,
   parameter int SW          = 3
) (
   input  logic          if_req,
   input  logic          d_req,
   input  logic [SW-1:0] dstreak,
   output logic          pick_if,
   output logic          pick_d
);

   logic fetch_turn;

   assign fetch_turn = (dstreak == SW'(MAX_DSTREAK));
   assign pick_d     = d_req & ~(if_req & fetch_turn);
   assign pick_if    = if_req & ~pick_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the cpu fetch and data ports.
//   One transaction outstanding at a time: IDLE -> ISSUE -> RESP -> IDLE,
//   or IDLE -> ERR -> IDLE for a misaligned data access (memory untouched).
//   Ports:
//     clk, reset                 clock, async active-low reset
//     if_req/if_addr             fetch request (word access)
//     if_rvalid/if_rdata         fetch completion pulse + instruction
//     d_req/d_we/d_size/d_addr/d_wdata   data request
//     d_rvalid/d_rdata/d_err     data completion pulse, load data, misalign flag
//     cpu_stall                  some cpu access is still in flight
//     mem_req/we/size/addr/wdata memory request, held until mem_gnt
//     mem_gnt/mem_rvalid/mem_rdata   memory handshake and response
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MAX_DSTREAK = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [2:0]      d_size,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_rvalid,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_err,
   output logic            cpu_stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [2:0]      mem_size,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);

   state_t        state, state_nx;
   owner_t        owner;
   logic [SW-1:0] dstreak;
   logic          pick_if, pick_d, d_mis;

   arb_pick #(.MAX_DSTREAK(MAX_DSTREAK), .SW(SW)) u_pick (
      .if_req  (if_req),
      .d_req   (d_req),
      .dstreak (dstreak),
      .pick_if (pick_if),
      .pick_d  (pick_d)
   );

   assign d_mis     = misaligned(d_size, d_addr[1:0]);
   assign cpu_stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Responses are steered combinationally so rvalid lands in the same
   // cycle as mem_rvalid; everything is gated by state, so a reset or a
   // stray response outside RESP produces all-zero outputs.
   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick_if)     state_nx = S_ISSUE;
            else if (pick_d) state_nx = d_mis ? S_ERR : S_ISSUE;
         end
         S_ISSUE: begin
            mem_req = 1'b1;
            if (mem_gnt) state_nx = S_RESP;
         end
         S_RESP: begin
            if (mem_rvalid) begin
               state_nx = S_IDLE;
               if (owner == OWN_IF) begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
               end else if (owner == OWN_D) begin
                  d_rvalid = 1'b1;
                  d_rdata  = mem_rdata;
               end
            end
         end
         S_ERR: begin
            d_rvalid = 1'b1;
            d_err    = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Request fields are captured on the way out of IDLE so the memory sees
   // stable values for however long it withholds mem_gnt.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner     <= OWN_NONE;
         dstreak   <= '0;
         mem_we    <= 1'b0;
         mem_size  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (state == S_IDLE) begin
         if (pick_if) begin
            owner     <= OWN_IF;
            mem_we    <= 1'b0;
            mem_size  <= SZ_W;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            dstreak   <= '0;
         end else if (pick_d && !d_mis) begin
            owner     <= OWN_D;
            mem_we    <= d_we;
            mem_size  <= d_size;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Only count grants that actually made fetch wait.
            if (!if_req)                          dstreak <= '0;
            else if (dstreak != SW'(MAX_DSTREAK)) dstreak <= dstreak + SW'(1);
         end
      end else if (state == S_RESP && mem_rvalid) begin
         owner <= OWN_NONE;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      logic        we;
   } gnt_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [2:0]  d_size;
   logic        mem_gnt, mem_rvalid;
   logic        if_rvalid, d_rvalid, d_err, cpu_stall, mem_req, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [2:0]  mem_size;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   gnt_wait = 0;
   logic drop_resp = 1'b0;
   logic auto_drop = 1'b1;

   gnt_t gq[$];
   rsp_t iq[$];
   rsp_t dq[$];

   mem_port_arbiter #(.XLEN(32), .MAX_DSTREAK(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mword(input logic [31:0] a);
      return a ^ 32'h005000D3;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_g(input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input logic we);
      gnt_t g;
      g.addr = a; g.wdata = wd; g.size = sz; g.we = we;
      gq.push_back(g);
   endtask

   task automatic push_r(input logic is_d, input logic [31:0] rd, input logic err);
      rsp_t r;
      r.rdata = rd; r.err = err;
      if (is_d) dq.push_back(r);
      else      iq.push_back(r);
   endtask

   // One clock of memory model + scoreboard. Called at posedge+2.
   task automatic cycle();
      logic        acc, w;
      logic [31:0] a;
      gnt_t        g;
      rsp_t        r;
      acc = mem_req & mem_gnt;
      a   = mem_addr;
      w   = mem_we;
      if (acc) begin
         chk("grant_queued", 64'(gq.size() > 0), 64'd1);
         if (gq.size() > 0) begin
            g = gq.pop_front();
            chk("grant_addr", 64'(mem_addr), 64'(g.addr));
            chk("grant_wdata", 64'(mem_wdata), 64'(g.wdata));
            chk("grant_we_size", 64'({mem_we, mem_size}), 64'({g.we, g.size}));
         end
      end
      @(posedge clk);
      #1;
      mem_rvalid = acc & ~drop_resp;
      mem_rdata  = (acc && !w) ? mword(a) : 32'h0;
      if (mem_req) begin
         if (gnt_wait > 0) begin mem_gnt = 1'b0; gnt_wait--; end
         else mem_gnt = 1'b1;
      end else mem_gnt = 1'b0;
      #1;
      if (if_rvalid) begin
         chk("if_rsp_queued", 64'(iq.size() > 0), 64'd1);
         if (iq.size() > 0) begin
            r = iq.pop_front();
            chk("if_rdata", 64'(if_rdata), 64'(r.rdata));
         end
         if (auto_drop) if_req = 1'b0;
      end
      if (d_rvalid) begin
         chk("d_rsp_queued", 64'(dq.size() > 0), 64'd1);
         if (dq.size() > 0) begin
            r = dq.pop_front();
            chk("d_rdata", 64'(d_rdata), 64'(r.rdata));
            chk("d_err", 64'(d_err), 64'(r.err));
         end
         if (auto_drop) d_req = 1'b0;
      end
   endtask

   task automatic run(input string tag, input int n, input int budget);
      int cnt = 0;
      int k   = 0;
      while (cnt < n && k < budget) begin
         cycle();
         cnt += int'(if_rvalid) + int'(d_rvalid);
         k++;
      end
      if (!auto_drop) begin if_req = 1'b0; d_req = 1'b0; end
      chk(tag, 64'(cnt), 64'(n));
   endtask

   task automatic drive_d(input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
      d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;

      // Reset state, with a stray response pending on the memory side
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_fields", 64'({mem_we, mem_size, mem_addr}), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_rvalid", 64'({if_rvalid, d_rvalid, d_err}), 64'd0);
      chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
      mem_rvalid = 1'b0; mem_rdata = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;

      // 1: fetch only, minimum latency
      if_req = 1'b1; if_addr = 32'h40;
      push_g(32'h40, 32'h0, SZ_W, 1'b0);
      push_r(1'b0, 32'h00500093, 1'b0);
      #1;
      chk("t1_stall_t0", 64'(cpu_stall), 64'd1);
      chk("t1_req_t0", 64'(mem_req), 64'd0);
      cycle();
      chk("t1_req_t1", 64'(mem_req), 64'd1);
      chk("t1_stall_t1", 64'(cpu_stall), 64'd1);
      cycle();
      chk("t1_rvalid_t2", 64'(if_rvalid), 64'd1);
      chk("t1_rdata_t2", 64'(if_rdata), 64'h00500093);
      cycle();
      chk("t1_rvalid_t3", 64'(if_rvalid), 64'd0);

      // 2: both at once -> data first, then fetch
      drive_d(1'b0, SZ_W, 32'h100, 32'h0);
      if_req = 1'b1; if_addr = 32'h44;
      push_g(32'h100, 32'h0, SZ_W, 1'b0);
      push_g(32'h44, 32'h0, SZ_W, 1'b0);
      push_r(1'b1, mword(32'h100), 1'b0);
      push_r(1'b0, mword(32'h44), 1'b0);
      run("t2_done", 2, 20);
      cycle();

      // 3: both held -> 4 data, 1 fetch, repeat
      auto_drop = 1'b0;
      drive_d(1'b0, SZ_W, 32'h200, 32'h0);
      if_req = 1'b1; if_addr = 32'h300;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            push_g(32'h200, 32'h0, SZ_W, 1'b0);
            push_r(1'b1, mword(32'h200), 1'b0);
         end
         push_g(32'h300, 32'h0, SZ_W, 1'b0);
         push_r(1'b0, mword(32'h300), 1'b0);
      end
      run("t3_done", 10, 100);
      auto_drop = 1'b1;
      cycle();

      // 4: misaligned SW -> error one cycle later, no memory request
      drive_d(1'b1, SZ_W, 32'h102, 32'hAAAA5555);
      push_r(1'b1, 32'h0, 1'b1);
      #1;
      cycle();
      chk("t4_rvalid", 64'(d_rvalid), 64'd1);
      chk("t4_err", 64'(d_err), 64'd1);
      chk("t4_memreq_t1", 64'(mem_req), 64'd0);
      cycle();
      chk("t4_memreq_t2", 64'(mem_req), 64'd0);
      chk("t4_rvalid_off", 64'(d_rvalid), 64'd0);
      // halfword boundaries: LH odd faults, LHU even and LB odd go to memory
      drive_d(1'b0, SZ_H, 32'h101, 32'h0);
      push_r(1'b1, 32'h0, 1'b1);
      run("t4_lh_odd", 1, 5);
      cycle();
      drive_d(1'b0, SZ_HU, 32'h102, 32'h0);
      push_g(32'h102, 32'h0, SZ_HU, 1'b0);
      push_r(1'b1, mword(32'h102), 1'b0);
      run("t4_lhu_even", 1, 8);
      cycle();
      drive_d(1'b0, SZ_B, 32'h103, 32'h0);
      push_g(32'h103, 32'h0, SZ_B, 1'b0);
      push_r(1'b1, mword(32'h103), 1'b0);
      run("t4_lb_odd", 1, 8);
      cycle();

      // 5: store with mem_gnt held off 5 cycles
      drive_d(1'b1, SZ_W, 32'h80, 32'hCAFEF00D);
      push_g(32'h80, 32'hCAFEF00D, SZ_W, 1'b1);
      push_r(1'b1, 32'h0, 1'b0);
      gnt_wait = 5;
      #1;
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("t5_req_held", 64'(mem_req), 64'd1);
         chk("t5_addr", 64'(mem_addr), 64'h80);
         chk("t5_wdata", 64'(mem_wdata), 64'hCAFEF00D);
         chk("t5_we_size", 64'({mem_we, mem_size}), 64'({1'b1, SZ_W}));
         cycle();
      end
      run("t5_done", 1, 5);
      cycle();

      // 6: reset in RESP, stray mem_rvalid afterwards
      drive_d(1'b0, SZ_W, 32'h10, 32'h0);
      push_g(32'h10, 32'h0, SZ_W, 1'b0);
      drop_resp = 1'b1;
      #1;
      cycle();
      cycle();
      chk("t6_in_resp", 64'({mem_req, d_rvalid}), 64'd0);
      #2;
      reset = 1'b0;
      #1;
      d_req = 1'b0;
      #1;
      chk("t6_rst_req", 64'(mem_req), 64'd0);
      chk("t6_rst_fields", 64'({mem_we, mem_size, mem_addr}), 64'd0);
      chk("t6_rst_wdata", 64'(mem_wdata), 64'd0);
      chk("t6_rst_rvalid", 64'({if_rvalid, d_rvalid, d_err, cpu_stall}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      drop_resp = 1'b0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      chk("t6_stray_rvalid", 64'({if_rvalid, d_rvalid, d_err}), 64'd0);
      chk("t6_stray_rdata", {if_rdata, d_rdata}, 64'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = '0;
      chk("t6_stray_after", 64'({if_rvalid, d_rvalid, mem_req}), 64'd0);
      // FSM must be back in IDLE: fresh fetch with normal latency
      if_req = 1'b1; if_addr = 32'h20;
      push_g(32'h20, 32'h0, SZ_W, 1'b0);
      push_r(1'b0, mword(32'h20), 1'b0);
      #1;
      cycle();
      chk("t6_fresh_req_t1", 64'(mem_req), 64'd1);
      cycle();
      chk("t6_fresh_rvalid_t2", 64'(if_rvalid), 64'd1);
      cycle();

      chk("end_grants_left", 64'(gq.size()), 64'd0);
      chk("end_if_left", 64'(iq.size()), 64'd0);
      chk("end_d_left", 64'(dq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
